// File: rtl/lif_pkg.sv
// Shared types, default sizing and the saturation helper for the LIF sweep controller.
package lif_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INIT,
    ST_RUN,
    ST_FINISH
  } state_t;

  localparam int unsigned DEF_NUM_NEURONS   = 128;
  localparam int unsigned DEF_VMEM_WIDTH    = 16;
  localparam int unsigned DEF_REF_CTR_WIDTH = 4;
  localparam int unsigned AW                = $clog2(DEF_NUM_NEURONS);
  localparam int unsigned STATE_WIDTH       = DEF_VMEM_WIDTH + DEF_REF_CTR_WIDTH;

  // Clamp a sign-extended value to the signed range of a w-bit word.
  function automatic logic signed [31:0] saturate(input logic signed [31:0] v,
                                                  input int unsigned        w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/lif_sweep_controller_spike_fifo.sv
// Synchronous spike-id FIFO with occupancy count; head output forced to zero when empty.
module spike_fifo
  import lif_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = AW,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = PW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             do_pop;
  logic             wr_ok;

  assign valid  = (count != '0);
  assign full   = (32'(count) == DEPTH);
  assign do_pop = valid && ready;
  assign wr_ok  = push && (!full || do_pop);
  assign dout   = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok)  wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_ok, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) assert (!(push && full && !do_pop));
  end

endmodule

// File: rtl/lif_sweep_controller.sv
// TDM leak/integrate/fire sweep over a neuron state LUTRAM with a queued spike output.
module lif_sweep_controller
  import lif_pkg::*;
#(
  parameter int unsigned                  NUM_NEURONS    = DEF_NUM_NEURONS,
  parameter int unsigned                  VMEM_WIDTH     = DEF_VMEM_WIDTH,
  parameter int unsigned                  REF_CTR_WIDTH  = DEF_REF_CTR_WIDTH,
  parameter int unsigned                  LEAK_SHIFT     = 4,
  parameter int unsigned                  REF_PERIOD     = 2,
  parameter logic signed [VMEM_WIDTH-1:0] V_RESET        = '0,
  parameter int unsigned                  SPK_FIFO_DEPTH = 8,
  parameter int unsigned                  ADDR_W         = $clog2(NUM_NEURONS)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_init,
  input  logic                            i_tick,
  input  logic signed [VMEM_WIDTH-1:0]    i_threshold,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_tick_drop,
  output logic [ADDR_W-1:0]               o_rd_addr,
  input  logic signed [VMEM_WIDTH-1:0]    i_vmem,
  input  logic [REF_CTR_WIDTH-1:0]        i_ref_ctr,
  input  logic signed [VMEM_WIDTH-1:0]    i_cur,
  output logic                            o_wr_en,
  output logic [ADDR_W-1:0]               o_wr_addr,
  output logic signed [VMEM_WIDTH-1:0]    o_vmem,
  output logic [REF_CTR_WIDTH-1:0]        o_ref_ctr,
  output logic                            o_spike_valid,
  output logic [ADDR_W-1:0]               o_spike_id,
  input  logic                            i_spike_ready
);

  localparam int unsigned CNT_W = $clog2(SPK_FIFO_DEPTH) + 1;

  state_t                        state;
  state_t                        state_nxt;
  logic [ADDR_W:0]               idx;
  logic                          s1_valid;
  logic [ADDR_W-1:0]             s1_addr;
  logic signed [VMEM_WIDTH-1:0]  threshold;
  logic [CNT_W-1:0]              fifo_count;
  logic                          issue;
  logic                          in_ref;
  logic                          fire;
  logic                          spike;
  logic signed [VMEM_WIDTH-1:0]  leak;
  logic signed [VMEM_WIDTH+1:0]  v_sum;
  logic signed [VMEM_WIDTH-1:0]  v_sat;

  // Counting the in-flight S1 neuron reserves its FIFO slot, so S1 never has to stall.
  assign issue = (state == ST_RUN) && (32'(idx) < NUM_NEURONS) &&
                 ((32'(fifo_count) + 32'(s1_valid)) < SPK_FIFO_DEPTH);

  always_comb begin
    state_nxt   = state;
    o_done      = 1'b0;
    o_tick_drop = 1'b0;
    case (state)
      ST_IDLE: begin
        o_tick_drop = i_tick && i_init;
        if (i_init)      state_nxt = ST_INIT;
        else if (i_tick) state_nxt = ST_RUN;
      end
      ST_INIT: begin
        o_tick_drop = i_tick;
        if (32'(idx) == NUM_NEURONS - 1) state_nxt = ST_FINISH;
      end
      ST_RUN: begin
        o_tick_drop = i_tick;
        if (32'(idx) == NUM_NEURONS && !s1_valid) state_nxt = ST_FINISH;
      end
      ST_FINISH: begin
        o_tick_drop = i_tick;
        o_done      = 1'b1;
        state_nxt   = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      s1_valid  <= 1'b0;
      s1_addr   <= '0;
      threshold <= '0;
    end else begin
      state    <= state_nxt;
      s1_valid <= issue;
      if (issue) s1_addr <= idx[ADDR_W-1:0];
      case (state)
        ST_IDLE: begin
          idx <= '0;
          if (!i_init && i_tick) threshold <= i_threshold;
        end
        ST_INIT: idx <= idx + (ADDR_W + 1)'(1);
        ST_RUN:  if (issue) idx <= idx + (ADDR_W + 1)'(1);
        default: idx <= idx;
      endcase
    end
  end

  assign o_busy    = (state == ST_INIT) || (state == ST_RUN);
  assign o_rd_addr = (state == ST_RUN) ? idx[ADDR_W-1:0] : '0;

  assign leak   = i_vmem >>> LEAK_SHIFT;
  assign v_sum  = {{2{i_vmem[VMEM_WIDTH-1]}}, i_vmem} - {{2{leak[VMEM_WIDTH-1]}}, leak}
                + {{2{i_cur[VMEM_WIDTH-1]}}, i_cur};
  assign v_sat  = VMEM_WIDTH'(saturate({{(30 - VMEM_WIDTH){v_sum[VMEM_WIDTH+1]}}, v_sum},
                                       VMEM_WIDTH));
  assign in_ref = (i_ref_ctr != '0);
  assign fire   = !in_ref && (v_sat >= threshold);
  assign spike  = s1_valid && fire;

  always_comb begin
    o_wr_en   = 1'b0;
    o_wr_addr = '0;
    o_vmem    = '0;
    o_ref_ctr = '0;
    if (state == ST_INIT) begin
      o_wr_en   = 1'b1;
      o_wr_addr = idx[ADDR_W-1:0];
      o_vmem    = V_RESET;
    end else if (s1_valid) begin
      o_wr_en   = 1'b1;
      o_wr_addr = s1_addr;
      if (in_ref) begin
        o_vmem    = V_RESET;
        o_ref_ctr = i_ref_ctr - REF_CTR_WIDTH'(1);
      end else if (fire) begin
        o_vmem    = V_RESET;
        o_ref_ctr = REF_CTR_WIDTH'(REF_PERIOD);
      end else begin
        o_vmem    = v_sat;
      end
    end
  end

  spike_fifo #(
    .DEPTH (SPK_FIFO_DEPTH),
    .WIDTH (ADDR_W)
  ) u_spike_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (spike),
    .din   (s1_addr),
    .ready (i_spike_ready),
    .valid (o_spike_valid),
    .dout  (o_spike_id),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_lif_sweep_controller.sv
// Directed scoreboard bench: LUTRAM/current-source model, expected writes and spikes queued at stimulus time.
module tb_lif_sweep_controller;
  import lif_pkg::*;

  localparam int N = 128;

  logic clk = 1'b0;
  logic rst_n;
  logic i_init, i_tick, i_spike_ready;
  logic signed [15:0] i_threshold, i_vmem, i_cur, o_vmem;
  logic [3:0] i_ref_ctr, o_ref_ctr;
  logic o_busy, o_done, o_tick_drop, o_wr_en, o_spike_valid;
  logic [AW-1:0] o_rd_addr, o_wr_addr, o_spike_id;

  always #5 clk = ~clk;

  lif_sweep_controller #(.NUM_NEURONS(N)) dut (
    .clk(clk), .rst_n(rst_n), .i_init(i_init), .i_tick(i_tick),
    .i_threshold(i_threshold), .o_busy(o_busy), .o_done(o_done),
    .o_tick_drop(o_tick_drop), .o_rd_addr(o_rd_addr), .i_vmem(i_vmem),
    .i_ref_ctr(i_ref_ctr), .i_cur(i_cur), .o_wr_en(o_wr_en),
    .o_wr_addr(o_wr_addr), .o_vmem(o_vmem), .o_ref_ctr(o_ref_ctr),
    .o_spike_valid(o_spike_valid), .o_spike_id(o_spike_id),
    .i_spike_ready(i_spike_ready)
  );

  typedef struct { int addr; int v; int r; } wr_t;

  logic signed [15:0] mem_v [N];
  logic [3:0]         mem_r [N];
  int cur [N];
  int model_v [N];
  int model_r [N];
  wr_t exp_wr [$];
  int  exp_spk [$];
  int checks = 0, errors = 0, cycle = 0;
  int writes = 0, done_cnt = 0, drop_cnt = 0, done_cycle = 0;
  logic [AW-1:0] rd_cap;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: check outputs at negedge, then serve the registered read data after posedge.
  task automatic cyc();
    wr_t e;
    @(negedge clk);
    if (o_wr_en) begin
      writes++;
      if (exp_wr.size() == 0) chk("wr_unexpected", longint'(o_wr_addr), -1);
      else begin
        e = exp_wr.pop_front();
        chk("wr_addr", longint'(o_wr_addr), e.addr);
        chk("wr_vmem", longint'(o_vmem), e.v);
        chk("wr_ref", longint'(o_ref_ctr), e.r);
      end
      mem_v[o_wr_addr] = o_vmem;
      mem_r[o_wr_addr] = o_ref_ctr;
    end
    if (o_spike_valid && i_spike_ready) begin
      if (exp_spk.size() == 0) chk("spk_unexpected", longint'(o_spike_id), -1);
      else chk("spk_id", longint'(o_spike_id), exp_spk.pop_front());
    end
    if (o_done) begin done_cnt++; done_cycle = cycle; end
    if (o_tick_drop) drop_cnt++;
    rd_cap = o_rd_addr;
    @(posedge clk);
    #1;
    i_vmem    = mem_v[rd_cap];
    i_ref_ctr = mem_r[rd_cap];
    i_cur     = 16'(cur[rd_cap]);
    cycle++;
  endtask

  function automatic void model_step(input int k, input int thr);
    int v, nv, nr;
    if (model_r[k] != 0) begin
      nv = 0; nr = model_r[k] - 1;
    end else begin
      v = model_v[k] - (model_v[k] >>> 4) + cur[k];
      if (v > 32767) v = 32767;
      if (v < -32768) v = -32768;
      if (v >= thr) begin nv = 0; nr = 2; exp_spk.push_back(k); end
      else begin nv = v; nr = 0; end
    end
    model_v[k] = nv;
    model_r[k] = nr;
    exp_wr.push_back('{k, nv, nr});
  endfunction

  task automatic preload(input int k, input int v, input int r);
    mem_v[k] = 16'(v); mem_r[k] = 4'(r);
    model_v[k] = v; model_r[k] = r;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) cyc();
    chk("done_seen", longint'(done_cnt - d0), 1);
    chk("wr_queue_empty", longint'(exp_wr.size()), 0);
  endtask

  task automatic start_tick(input int thr);
    i_threshold = 16'(thr);
    for (int k = 0; k < N; k++) model_step(k, thr);
    i_tick = 1'b1;
    cyc();
    i_tick = 1'b0;
  endtask

  task automatic do_init(input logic with_tick);
    for (int k = 0; k < N; k++) begin
      exp_wr.push_back('{k, 0, 0});
      model_v[k] = 0; model_r[k] = 0;
    end
    i_init = 1'b1; i_tick = with_tick;
    cyc();
    i_init = 1'b0; i_tick = 1'b0;
    wait_done(200);
  endtask

  initial begin
    int t0, w0, d0, x0;
    rst_n = 1'b0; i_init = 1'b0; i_tick = 1'b0; i_spike_ready = 1'b1;
    i_threshold = '0; i_vmem = '0; i_cur = '0; i_ref_ctr = '0;
    for (int k = 0; k < N; k++) begin cur[k] = 0; mem_v[k] = '0; mem_r[k] = '0; end
    repeat (3) cyc();
    chk("rst_busy", o_busy, 0);          chk("rst_done", o_done, 0);
    chk("rst_wr_en", o_wr_en, 0);        chk("rst_rd_addr", o_rd_addr, 0);
    chk("rst_spike_valid", o_spike_valid, 0);
    chk("rst_spike_id", o_spike_id, 0);  chk("rst_vmem", o_vmem, 0);
    rst_n = 1'b1;
    cyc();

    w0 = writes;
    do_init(1'b0);
    chk("init_writes", writes - w0, N);

    preload(5, 160, 0);
    start_tick(1000); wait_done(200);
    chk("leak_v5", mem_v[5], 150);  chk("leak_r5", mem_r[5], 0);

    preload(5, 1000, 0); cur[5] = 100;
    start_tick(1000); wait_done(200);
    chk("spk_v5", mem_v[5], 0);     chk("spk_r5", mem_r[5], 2);
    repeat (3) cyc();
    chk("spk_queue_empty", exp_spk.size(), 0);
    cur[5] = 500;
    start_tick(1000); wait_done(200);
    chk("ref1_v5", mem_v[5], 0);    chk("ref1_r5", mem_r[5], 1);
    start_tick(1000); wait_done(200);
    chk("ref0_v5", mem_v[5], 0);    chk("ref0_r5", mem_r[5], 0);
    start_tick(1000); wait_done(200);
    chk("post_ref_v5", mem_v[5], 500);

    preload(7, -32000, 0); cur[7] = -32768;
    start_tick(1000); wait_done(200);
    chk("negsat_v7", mem_v[7], -32768);

    t0 = cycle; x0 = drop_cnt; d0 = done_cnt;
    start_tick(1000);
    chk("busy_T1", o_busy, 1);
    while (cycle < t0 + 10) cyc();
    i_tick = 1'b1; cyc(); i_tick = 1'b0;
    chk("tick_drop", drop_cnt - x0, 1);
    wait_done(200);
    chk("done_latency", done_cycle - t0, N + 3);
    repeat (10) cyc();
    chk("single_done", done_cnt - d0, 1);
    chk("no_extra_busy", o_busy, 0);

    for (int k = 0; k < N; k++) begin preload(k, 0, 0); cur[k] = 2000; end
    i_spike_ready = 1'b0;
    w0 = writes; d0 = done_cnt;
    start_tick(1000);
    repeat (40) cyc();
    chk("bp_writes", writes - w0, 8);
    chk("bp_busy", o_busy, 1);
    chk("bp_rd_hold", o_rd_addr, 8);
    chk("bp_head_valid", o_spike_valid, 1);
    chk("bp_head_id", o_spike_id, 0);
    i_spike_ready = 1'b1;
    wait_done(400);
    chk("bp_total_writes", writes - w0, N);
    for (int i = 0; i < 20 && exp_spk.size() != 0; i++) cyc();
    chk("bp_spikes_drained", exp_spk.size(), 0);
    chk("bp_done_once", done_cnt - d0, 1);

    x0 = drop_cnt; w0 = writes;
    do_init(1'b1);
    chk("prio_drop", drop_cnt - x0, 1);
    chk("prio_writes", writes - w0, N);

    i_spike_ready = 1'b0;
    start_tick(1000);
    repeat (20) cyc();
    rst_n = 1'b0;
    #1;
    chk("arst_busy", o_busy, 0);       chk("arst_wr_en", o_wr_en, 0);
    chk("arst_rd_addr", o_rd_addr, 0); chk("arst_spike_valid", o_spike_valid, 0);
    chk("arst_done", o_done, 0);
    exp_wr.delete(); exp_spk.delete();
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    chk("post_rst_fifo_empty", o_spike_valid, 0);
    chk("post_rst_idle", o_busy, 0);
    i_spike_ready = 1'b1;
    do_init(1'b0);
    for (int k = 0; k < N; k++) cur[k] = 0;
    start_tick(1000); wait_done(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lif_sweep_controller.md
Name: lif_sweep_controller

Overview:
- TDM update engine for one LIF neuron group.
- On each timestep tick it sweeps neuron indices 0..NUM_NEURONS-1. For each neuron it:
  - reads the neuron's state from the neuron state LUTRAM, along with that neuron's synaptic current from the accumulator (same address, same 1-cycle latency);
  - applies leak, integrate, threshold and refractory;
  - writes the result back to the LUTRAM.
- Spikes are queued in an internal FIFO for the downstream fan-out stage.
- An init sweep clears the state memory, which has no reset.

Parameters:
- NUM_NEURONS, 128, neurons in the group; AW = $clog2(NUM_NEURONS).
- VMEM_WIDTH, 16, signed membrane potential width.
- REF_CTR_WIDTH, 4, refractory counter width.
- LEAK_SHIFT, 4, leak is vmem >>> LEAK_SHIFT.
- REF_PERIOD, 2, refractory ticks loaded on a spike; must be < 2^REF_CTR_WIDTH.
- V_RESET, 0, vmem after a spike, during refractory, and after init.
- SPK_FIFO_DEPTH, 8, spike FIFO entries; power of 2, ≥ 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_init  in  1  pulse: start init sweep
- i_tick  in  1  pulse: start timestep sweep
- i_threshold  in  VMEM_WIDTH  signed firing threshold, sampled when a tick is accepted
- o_busy  out  1  sweep in progress
- o_done  out  1  1-cycle pulse: sweep finished
- o_tick_drop  out  1  1-cycle pulse: tick ignored
- o_rd_addr  out  AW  LUTRAM read address, also the current-source address
- i_vmem  in  VMEM_WIDTH  signed LUTRAM read data, valid 1 cycle after o_rd_addr
- i_ref_ctr  in  REF_CTR_WIDTH  LUTRAM read data, valid 1 cycle after o_rd_addr
- i_cur  in  VMEM_WIDTH  signed synaptic current, valid 1 cycle after o_rd_addr
- o_wr_en  out  1  LUTRAM write enable
- o_wr_addr  out  AW  LUTRAM write address
- o_vmem  out  VMEM_WIDTH  vmem write data
- o_ref_ctr  out  REF_CTR_WIDTH  ref counter write data
- o_spike_valid  out  1  spike FIFO not empty
- o_spike_id  out  AW  FIFO head neuron index
- i_spike_ready  in  1  downstream accepts the head this cycle

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; FIFO empty.
  - Reset mid-sweep aborts the sweep; memory contents are undefined until an init sweep completes.
- FSM states: IDLE, INIT, RUN, FINISH.
- IDLE:
  - i_init moves to INIT.
  - Otherwise i_tick moves to RUN and latches i_threshold.
  - i_init and i_tick in the same cycle: init wins, and o_tick_drop pulses.
- INIT:
  - Write {0, V_RESET} to addresses 0..NUM_NEURONS-1, one per cycle, starting the cycle after acceptance.
  - After the last write, go to FINISH. No reads and no spikes occur.
- RUN, 2-stage pipeline:
  - S0 issues o_rd_addr = k.
  - S1, the following cycle, computes from i_vmem/i_ref_ctr/i_cur and drives o_wr_en/o_wr_addr = k that same cycle.
- RUN issue gating:
  - Read k is issued only if fifo_count + s1_valid < SPK_FIFO_DEPTH. Otherwise o_rd_addr holds and no read is issued.
  - Hence S1 never stalls and every issued neuron is written exactly once.
- RUN unstalled timing, with tick accepted at cycle T:
  - read k issued at T+1+k;
  - write k at T+2+k;
  - o_done pulses at T+N+3;
  - o_busy is high T+1..T+N+2.
- FINISH: one cycle, pulses o_done, returns to IDLE. o_busy is low in IDLE.
- i_tick while not in IDLE: ignored, and o_tick_drop pulses.
- i_init while not in IDLE: ignored.
- Update rule when ref_ctr ≠ 0:
  - vmem' = V_RESET;
  - ref' = ref_ctr − 1;
  - no spike.
- Update rule when ref_ctr = 0:
  - compute v = vmem − (vmem >>> LEAK_SHIFT) + cur in VMEM_WIDTH+2 bits;
  - saturate v to the signed VMEM_WIDTH range;
  - if v ≥ threshold (signed compare): spike, vmem' = V_RESET, ref' = REF_PERIOD;
  - else vmem' = v, ref' = 0.
- Spike FIFO:
  - A spike pushes id k in the S1 cycle.
  - Pop when o_spike_valid && i_spike_ready.
  - Simultaneous push and pop is legal, and the count is unchanged.
  - Order is ascending id within a tick.
  - The FIFO is not required to drain before o_done; leftover entries persist into the next tick.
  - Overflow is impossible by construction; an assertion checks it.

Decomposition:
- Package lif_pkg holds:
  - FSM state enum;
  - localparams AW and STATE_WIDTH = VMEM_WIDTH + REF_CTR_WIDTH;
  - saturate function.
- One sub-module, spike_fifo: synchronous FIFO with count output, parameterised depth and width AW.

Test Plan:
- Leak: init, preload neuron 5 with vmem=160, cur=0, threshold 1000, tick → write neuron 5 vmem=150, ref=0, no spike.
- Spike and refractory:
  - vmem=1000, cur=100, threshold=1000 → 938+100=1038, spike id 5, write vmem 0, ref 2.
  - Next two ticks with cur=500 → ref 1 then 0, vmem 0, no spike.
  - Third tick → vmem 500.
- Negative saturation: vmem=−32000, cur=−32768 → −62768 clamps to −32768, written, no spike.
- Backpressure: all 128 neurons cur=2000, threshold=1000, i_spike_ready=0 → exactly 8 spikes queued, reads stall, o_busy stays 1. Raise ready → ids 0..127 in order, 128 writes total, o_done once.
- Timing/drop: tick at cycle T with ready=1 → o_done at T+131. Second tick at T+10 → o_tick_drop pulse, no extra sweep.
- Init priority/reset: i_init and i_tick together → 128 writes of {0,0}, o_tick_drop=1. rst_n low mid-RUN → outputs 0 immediately, FIFO empty.
